// File: rtl/led_flags_pkg.sv
// Shared definitions for the LED panel flag-port handshake block:
// flag bit positions, output-enable mask, command codes and FSM states.
package led_flags_pkg;

   // Bit positions on the 8-bit bidirectional flag port
   localparam int FLAG_REQ    = 0;
   localparam int FLAG_ACK    = 1;
   localparam int FLAG_CMD_LO = 2;
   localparam int FLAG_BUSY   = 4;
   localparam int FLAG_ERR    = 5;

   // Bits owned (driven) by the fabric: ACK, BUSY, ERR
   localparam logic [7:0] FLAGS_OE_MASK = 8'h32;

   // Panel command codes carried in the CMD field
   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_SWAP  = 2'd1;
   localparam logic [1:0] CMD_CLEAR = 2'd2;
   localparam logic [1:0] CMD_BLIT  = 2'd3;

   // Handshake FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/led_flag_sync.sv
// Multi-flop synchroniser for the asynchronous flag bus plus the REQ
// rising-edge detector. SYNC_STAGES is meant to be 2 or 3.
// The REQ bit of every stage resets high: a REQ that is already asserted
// when reset is released then looks like a steady high, not a new rise,
// and the CPU must drop and re-raise REQ before a request is seen.
module led_flag_sync
   import led_flags_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] flags_in,
   output logic [7:0] flags_s,
   output logic       req_s,
   output logic       req_rise
);

   localparam logic [7:0] SYNC_RST = 8'(1) << FLAG_REQ;

   logic [7:0] sync_q [SYNC_STAGES];
   logic       req_d_q;

   // Shift the pad value through the synchroniser chain and delay REQ once more
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= SYNC_RST;
         end
         req_d_q <= 1'b1;
      end else begin
         sync_q[0] <= flags_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         req_d_q <= sync_q[SYNC_STAGES-1][FLAG_REQ];
      end
   end

   assign flags_s  = sync_q[SYNC_STAGES-1];
   assign req_s    = flags_s[FLAG_REQ];
   assign req_rise = req_s & ~req_d_q;

endmodule

// File: rtl/led_flag_handshake.sv
// Fabric-side consumer of the CPU flag port. Runs a four-phase REQ/ACK
// handshake with the CPU and turns each request into one valid/ready
// command toward the panel framebuffer controller, with a cmd_done timeout.
//
// Command handshake: cmd_valid rises with a request and, together with
// cmd_code, stays stable until the cycle where cmd_valid & cmd_ready are both
// high; that cycle is the transfer and cmd_valid is low in the next cycle.
//
// Optional macro LED_FLAG_HANDSHAKE_IRQ_EN: when defined, irq is a registered
// level high for exactly the time the FSM sits in DONE; otherwise irq is 0.
module led_flag_handshake
   import led_flags_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int TW             = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] flags_in,
   output logic [7:0] flags_out,
   output logic [7:0] flags_oe,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_code,
   input  logic       cmd_done,
   output logic       irq,
   output fsm_state_t dbg_state
);

   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [7:0] flags_s;
   logic       req_s;
   logic       req_rise;
   logic       unused_flags;

   fsm_state_t    state_q, state_d;
   logic [1:0]    cmd_code_q, cmd_code_d;
   logic          err_q, err_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          cmd_valid_q;
   logic          busy_q;
   logic          ack_q;

   led_flag_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .flags_in (flags_in),
      .flags_s  (flags_s),
      .req_s    (req_s),
      .req_rise (req_rise)
   );

   // Only REQ and CMD are consumed here; the rest of the bus is ignored
   assign unused_flags = ^{flags_s[7:4], flags_s[1:0]};

   // Next-state, command latch, error and timeout counter decisions
   always_comb begin
      state_d    = state_q;
      cmd_code_d = cmd_code_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_rise) begin
               cmd_code_d = flags_s[FLAG_CMD_LO +: 2];
               err_d      = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_valid_q && cmd_ready) begin
               cnt_d   = '0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q + TW'(1);
            // A completion in the final count still counts as success
            if (cmd_done) begin
               err_d   = 1'b0;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!req_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state so every
   // output pin comes straight from a flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_code_q  <= CMD_NOP;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_code_q  <= cmd_code_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         cmd_valid_q <= (state_d == ISSUE);
         busy_q      <= (state_d == ISSUE) || (state_d == EXEC);
         ack_q       <= (state_d == DONE);
      end
   end

`ifdef LED_FLAG_HANDSHAKE_IRQ_EN
   logic irq_q;

   // Completion interrupt: high for the whole DONE residency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (state_d == DONE);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Pack the block-owned flag bits; reserved and CPU-owned bits stay 0
   always_comb begin
      flags_out            = 8'h00;
      flags_out[FLAG_ACK]  = ack_q;
      flags_out[FLAG_BUSY] = busy_q;
      flags_out[FLAG_ERR]  = err_q;
   end

   assign flags_oe  = FLAGS_OE_MASK;
   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_led_flag_handshake.sv
// Directed bench for led_flag_handshake (SYNC_STAGES=2, TIMEOUT_CYCLES=16).
module tb_led_flag_handshake;
  import led_flags_pkg::*;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TW             = 16;

`ifdef LED_FLAG_HANDSHAKE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] flags_in;
  logic [7:0] flags_out;
  logic [7:0] flags_oe;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       cmd_done;
  logic       irq;
  fsm_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_flag_handshake #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flags_in  (flags_in),
    .flags_out (flags_out),
    .flags_oe  (flags_oe),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_done  (cmd_done),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance n active edges; inputs are driven and outputs sampled 1ns after
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise REQ with a command and wait until cmd_valid is due
  task automatic raise_req(input logic [1:0] code);
    flags_in = 8'h01 | (8'(code) << 2);
    tick(SYNC_STAGES + 1);
  endtask

  // Transfer the pending command
  task automatic accept_cmd();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    reset     = 1'b1;
    flags_in  = 8'h01;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    tick(3);
    reset = 1'b0;
    n_checks++;
    if (flags_out !== 8'h00) begin n_errors++; $display("FAIL reset_flags_out: got %h want 00", flags_out); end
    n_checks++;
    if (flags_oe !== 8'h32) begin n_errors++; $display("FAIL reset_flags_oe: got %h want 32", flags_oe); end
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 2'd0 || irq !== 1'b0) begin
      n_errors++; $display("FAIL reset_cmd: valid=%b code=%0d irq=%b want 0 0 0", cmd_valid, cmd_code, irq);
    end
    // REQ held high across reset release is not a request
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cmd_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL req_high_at_reset: cmd_valid high in %0d cycles want 0", bad); end
    n_checks++;
    if (dbg_state !== IDLE) begin n_errors++; $display("FAIL req_high_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_req_latency();
    flags_in = 8'h00;
    tick(4);
    flags_in = 8'h09;  // REQ=1, CMD=2
    tick(SYNC_STAGES);
    n_checks++;
    if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL valid_early: got %b want 0", cmd_valid); end
    tick(1);
    n_checks++;
    if (cmd_valid !== 1'b1) begin n_errors++; $display("FAIL valid_latency: got %b want 1", cmd_valid); end
    n_checks++;
    if (cmd_code !== CMD_CLEAR) begin n_errors++; $display("FAIL cmd_code_clear: got %0d want 2", cmd_code); end
    n_checks++;
    if (flags_out !== 8'h10) begin n_errors++; $display("FAIL busy_on_issue: got %h want 10", flags_out); end
  endtask

  task automatic test_ready_stall();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cmd_valid !== 1'b1 || cmd_code !== CMD_CLEAR || flags_out !== 8'h10) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL stall_stable: unstable in %0d cycles want 0", bad); end
    accept_cmd();
    n_checks++;
    if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL valid_drop: got %b want 0", cmd_valid); end
    n_checks++;
    if (dbg_state !== EXEC) begin n_errors++; $display("FAIL enter_exec: got %0d want %0d", dbg_state, EXEC); end
  endtask

  task automatic test_done_ack();
    tick(4);  // EXEC cycle 4
    n_checks++;
    if (flags_out !== 8'h10) begin n_errors++; $display("FAIL exec_flags: got %h want 10", flags_out); end
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    n_checks++;
    if (flags_out !== 8'h02) begin n_errors++; $display("FAIL done_ack: got %h want 02", flags_out); end
    n_checks++;
    if (irq !== IRQ_ON) begin n_errors++; $display("FAIL irq_set: got %b want %b", irq, IRQ_ON); end
    tick(3);
    n_checks++;
    if (dbg_state !== DONE) begin n_errors++; $display("FAIL hold_done: got %0d want %0d", dbg_state, DONE); end
    flags_in = 8'h00;
    tick(SYNC_STAGES);
    n_checks++;
    if (flags_out !== 8'h02) begin n_errors++; $display("FAIL ack_hold_sync: got %h want 02", flags_out); end
    tick(1);
    n_checks++;
    if (flags_out !== 8'h00) begin n_errors++; $display("FAIL ack_clear: got %h want 00", flags_out); end
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_timeout();
    raise_req(CMD_BLIT);
    n_checks++;
    if (cmd_code !== CMD_BLIT) begin n_errors++; $display("FAIL cmd_code_blit: got %0d want 3", cmd_code); end
    accept_cmd();
    tick(TIMEOUT_CYCLES - 1);
    n_checks++;
    if (dbg_state !== EXEC) begin n_errors++; $display("FAIL timeout_early: got %0d want %0d", dbg_state, EXEC); end
    tick(1);
    n_checks++;
    if (flags_out !== 8'h22) begin n_errors++; $display("FAIL timeout_err: got %h want 22", flags_out); end
    flags_in = 8'h00;
    tick(SYNC_STAGES + 1);
    n_checks++;
    if (flags_out !== 8'h20) begin n_errors++; $display("FAIL err_persist: got %h want 20", flags_out); end
    raise_req(CMD_SWAP);
    n_checks++;
    if (flags_out !== 8'h10 || cmd_code !== CMD_SWAP) begin
      n_errors++; $display("FAIL err_clear: flags=%h code=%0d want 10 1", flags_out, cmd_code);
    end
  endtask

  task automatic test_done_on_last_count();
    accept_cmd();
    tick(TIMEOUT_CYCLES - 1);  // counter now at its last value
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    n_checks++;
    if (flags_out !== 8'h02) begin n_errors++; $display("FAIL done_wins: got %h want 02", flags_out); end
    // Stray completion while in DONE
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    tick(1);
    n_checks++;
    if (dbg_state !== DONE || flags_out !== 8'h02) begin
      n_errors++; $display("FAIL stray_done_in_done: state=%0d flags=%h want 3 02", dbg_state, flags_out);
    end
    flags_in = 8'h00;
    tick(SYNC_STAGES + 1);
    // Stray completion while in IDLE
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    tick(3);
    n_checks++;
    if (dbg_state !== IDLE || flags_out !== 8'h00 || cmd_valid !== 1'b0) begin
      n_errors++; $display("FAIL stray_done_in_idle: state=%0d flags=%h valid=%b want 0 00 0", dbg_state, flags_out, cmd_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    raise_req(CMD_CLEAR);
    accept_cmd();
    tick(2);
    n_checks++;
    if (dbg_state !== EXEC) begin n_errors++; $display("FAIL pre_reset_exec: got %0d want %0d", dbg_state, EXEC); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (flags_out !== 8'h00 || cmd_valid !== 1'b0 || cmd_code !== 2'd0 || irq !== 1'b0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL async_reset: flags=%h valid=%b code=%0d irq=%b state=%0d want all 0",
               flags_out, cmd_valid, cmd_code, irq, dbg_state);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    tick(5);
    n_checks++;
    if (flags_out !== 8'h00 || cmd_valid !== 1'b0) begin
      n_errors++; $display("FAIL done_after_reset: flags=%h valid=%b want 00 0", flags_out, cmd_valid);
    end
    flags_in = 8'h00;
    tick(2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_req_latency();
    test_ready_stall();
    test_done_ack();
    test_timeout();
    test_done_on_last_count();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_flag_handshake.md
Name: led_flag_handshake

Overview:
- Fabric-side consumer of the CPU's 8-bit bidirectional flag port, which drives the LED panel write-control flags.
- Synchronises the flags and runs a four-phase REQ/ACK handshake with the CPU.
- Turns each request into a single-cycle valid/ready command toward the panel framebuffer controller.
- Reports BUSY, ACK and ERR back on the flag bits it owns.

Parameters:
- SYNC_STAGES, 2, flops in the flags_in synchroniser; legal range 2..3.
- TIMEOUT_CYCLES, 65535, maximum cycles spent waiting for cmd_done before the command is aborted.
- TW, 16, timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- flags_in  in  8  bidir flag bus as seen at the pad; asynchronous to clk.
- flags_out  out  8  values driven on the block-owned bits.
- flags_oe  out  8  output enables; constant 8'b0011_0010 (bits 1, 4, 5).
- cmd_valid  out  1  command valid toward the panel controller.
- cmd_ready  in  1  panel controller accepts the command.
- cmd_code  out  2  latched command code (CMD field).
- cmd_done  in  1  single-cycle pulse when the panel controller finishes.
- irq  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Flag map:
  - bit0 REQ (CPU drives).
  - bit1 ACK (block drives).
  - bits[3:2] CMD (CPU drives).
  - bit4 BUSY (block drives).
  - bit5 ERR (block drives).
  - bits[7:6] reserved: ignored, driven 0.
- Synchronisation: flags_in passes through SYNC_STAGES flops. req_s is the synchronised bit0; req_rise is req_s & ~req_s_d.
- Reset: state=IDLE; flags_out, cmd_valid, cmd_code, irq, err and timeout counter all 0.
- State IDLE:
  - On req_rise: latch CMD (synchronised bits[3:2]) into cmd_code, clear err, set BUSY, go to ISSUE.
  - REQ already high when leaving reset is not a rise; the block stays in IDLE until REQ goes low and then high again.
- State ISSUE:
  - cmd_valid=1 and cmd_code held stable until cmd_ready. Transfer occurs in the cycle with cmd_valid & cmd_ready.
  - Next cycle: cmd_valid=0, counter cleared, go to EXEC.
  - REQ dropping while in ISSUE is ignored; the command completes.
- State EXEC:
  - Counter increments each cycle.
  - cmd_done goes to DONE with err=0.
  - Counter reaching TIMEOUT_CYCLES−1 without cmd_done goes to DONE with err=1.
  - cmd_done wins if it coincides with the last count.
- State DONE:
  - ACK=1, ERR=err, BUSY=0.
  - When req_s is low: ACK=0, go to IDLE. ERR stays latched until the next accepted request.
- Timing:
  - cmd_done pulses outside EXEC are ignored.
  - Handshake latency: cmd_valid asserts one cycle after req_rise. ACK asserts one cycle after cmd_done.
- flags_out changes only on clk edges (registered, glitch-free).
- Reset asserted mid-operation returns everything to reset values immediately. An in-flight panel command is abandoned.

Optional Feature:
- Macro: LED_FLAG_HANDSHAKE_IRQ_EN.
- Defined: irq is a registered level, set on entry to DONE and cleared on the same edge that leaves DONE, which occurs when REQ has fallen.
- Undefined: irq is tied to 0 and no irq flop exists.

Decomposition:
- Package led_flags_pkg holds:
  - Bit indices FLAG_REQ=0, FLAG_ACK=1, FLAG_CMD_LO=2, FLAG_BUSY=4, FLAG_ERR=5.
  - FLAGS_OE_MASK = 8'h32.
  - Command codes CMD_NOP=0, CMD_SWAP=1, CMD_CLEAR=2, CMD_BLIT=3.
  - State enum IDLE/ISSUE/EXEC/DONE.
- Sub-module led_flag_sync: a parameterised SYNC_STAGES-deep synchroniser on all 8 bits plus the REQ rising-edge detector. The FSM and timeout counter stay in the top level.

Test Plan:
- Reset with REQ=1 held → state IDLE, cmd_valid never asserts. Drop REQ for 4 cycles, raise it with CMD=2 → cmd_code=2 and cmd_valid=1 exactly SYNC_STAGES+1 cycles after the pad edge.
- cmd_ready held low 10 cycles → cmd_valid and cmd_code stable throughout, BUSY=1. cmd_ready=1 → cmd_valid drops next cycle.
- cmd_done 5 cycles into EXEC → ACK=1, BUSY=0, ERR=0. REQ low → ACK=0 after sync delay; irq (if enabled) follows the same set and clear timing.
- TIMEOUT_CYCLES=16 with no cmd_done → DONE entered after 16 EXEC cycles with ERR=1. ERR persists after REQ falls and clears on the next request.
- Reset pulsed during EXEC → all outputs 0 asynchronously. A later cmd_done pulse while in IDLE causes no ACK.
- cmd_done coincident with the final timeout count → ERR=0. A stray cmd_done in IDLE or DONE is ignored.
